frame_uart_dumper: RTL and testbench
====================================

// Module: frame_uart_dumper
// PURPOSE
// - Downstream of the downsample buffer: walks the COLS x ROWS grid of 32-bit words.
// - Serialises each word MSB byte first into single-cycle byte strobes for the uart core.
// - Enforces an idle holdoff between bytes so the host can resynchronise.
// - Replaces the ad-hoc inline sequencer in the board top level.
// PARAMETERS
// COLS          40  words per row; read_x counts 0..COLS-1
// ROWS          30  rows per frame; read_y counts 0..ROWS-1
// HOLDOFF_BITS  13  holdoff counter width; holdoff = 2^HOLDOFF_BITS-1 cycles
// READ_LAT      1   cycles from read_x/read_y change to read_q valid
// CONTINUOUS    1   1: restart a frame automatically after done; 0: wait for start_i
// PORTS
// sys_clk_i    in   1   system clock (12 MHz on board); single clock domain
// sys_rst_i    in   1   synchronous active-high reset
// start_i      in   1   frame start request; level-sampled in IDLE only
// read_x       out  6   buffer column address
// read_y       out  5   buffer row address
// read_q       in   32  buffer read data, valid READ_LAT cycles after address
// uart_dat_o   out  8   byte to transmit; stable while uart_wr_o=1
// uart_wr_o    out  1   one-cycle write strobe to uart
// uart_busy_i  in   1   uart transmitting
// busy_o       out  1   high from leaving IDLE until DONE
// done_o       out  1   one-cycle pulse after the last byte of a frame is strobed
// BEHAVIOUR
// - Reset values: read_x=0, read_y=0, uart_dat_o=0, uart_wr_o=0, busy_o=0, done_o=0.
// - Reset also clears the holdoff counter and the byte index, and the state returns to IDLE.
// - Reset mid-frame abandons the frame; no partial byte strobe is issued afterwards.
// - Holdoff counter: cleared on any cycle with uart_busy_i=1 or uart_wr_o=1; otherwise
//   increments and saturates at all-ones. "ready" = counter all-ones & !uart_busy_i & !uart_wr_o.
// - States:
//   - IDLE: when (CONTINUOUS | start_i), clear x/y/byte index -> HDR (if enabled) or ADDR.
//   - ADDR: drive read_x/read_y; wait READ_LAT cycles -> LATCH.
//   - LATCH: capture read_q into 32-bit shift register; byte index=0 -> SEND.
//   - SEND: on ready, pulse uart_wr_o with shreg[31:24], shift left 8, index++.
//     After the 4th strobe -> NEXT.
//   - NEXT: advance the address.
//     - x==COLS-1: x=0, y++.
//     - x==COLS-1 & y==ROWS-1: -> DONE.
//     - Otherwise -> ADDR.
//   - DONE: done_o=1 for one cycle, busy_o=0 -> IDLE.
// - Strobe spacing: consecutive strobes are separated by at least 2^HOLDOFF_BITS cycles.
// - A byte is never issued while uart_busy_i=1.
// - Ordering: y outer, x inner, byte 31:24 first. Frame = COLS*ROWS*4 payload bytes.
// - read_x/read_y hold steady from ADDR through SEND; changes occur only in NEXT/IDLE.
// - start_i outside IDLE is ignored.
// - uart_busy_i asserted with no write pending: the holdoff restarts and nothing else changes.
// CONFIGURATION
// - FRAME_DUMP_HEADER_EN defined:
//   - HDR state precedes the first ADDR of every frame.
//   - Sends 4 bytes 0xA5, 0x5A, COLS[7:0], ROWS[7:0] with the same ready/holdoff rules.
//   - Frame length is then COLS*ROWS*4+4 bytes.
// - FRAME_DUMP_HEADER_EN undefined: no HDR state; IDLE goes directly to ADDR.
//   The output is byte-identical to the payload stream only.
// TESTING
// - Bench parameters: HOLDOFF_BITS=2, COLS=2, ROWS=2.
// - Bench models: uart with busy high 5 cycles after each strobe; buffer returning
//   {y,x} patterned words at READ_LAT=1.
// - Directed scenarios:
//   1. Word 0x11223344 at (0,0) -> strobes 0x11,0x22,0x33,0x44 in order, >=4 cycles apart.
//   2. Full frame -> 16 strobes, order (0,0),(1,0),(0,1),(1,1).
//      Then done_o pulses once and busy_o falls the same cycle.
//   3. CONTINUOUS=0, start_i low -> no strobes for 100 cycles.
//      One-cycle start_i pulse -> exactly one frame.
//   4. Hold uart_busy_i high 50 cycles mid-word -> no strobe while busy.
//      Next strobe arrives >=4 cycles after busy falls; no byte lost or duplicated.
//   5. Assert sys_rst_i after the 6th strobe -> all outputs return to reset values
//      the next cycle; the next frame restarts at (0,0) byte 0x..31:24.
//   6. With FRAME_DUMP_HEADER_EN -> first strobes 0xA5,0x5A,0x02,0x02, then 16 payload bytes.
//      Without the macro -> the first strobe is the payload MSB.

Source files
------------

// File: rtl/frame_uart_dumper.sv
// frame_uart_dumper: walks a COLS x ROWS grid of 32-bit buffer words and
// serialises each word MSB byte first as single-cycle strobes to a uart core.
// Consecutive strobes are spaced by an idle holdoff so the host can resync.
// Optional build macro FRAME_DUMP_HEADER_EN prepends a 4-byte header
// (0xA5, 0x5A, COLS[7:0], ROWS[7:0]) to every frame.
//
// Uart handshake: uart_wr_o is a one-cycle strobe with uart_dat_o stable in
// that cycle; a strobe is only launched from a cycle where uart_busy_i=0,
// no strobe is already out, and the holdoff counter has saturated.
module frame_uart_dumper #(
  parameter int COLS         = 40,
  parameter int ROWS         = 30,
  parameter int HOLDOFF_BITS = 13,
  parameter int READ_LAT     = 1,
  parameter int CONTINUOUS   = 1
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        start_i,
  output logic [5:0]  read_x,
  output logic [4:0]  read_y,
  input  logic [31:0] read_q,
  output logic [7:0]  uart_dat_o,
  output logic        uart_wr_o,
  input  logic        uart_busy_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    LATCH = 3'd2,
    SEND  = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
`ifdef FRAME_DUMP_HEADER_EN
    , HDR = 3'd6
`endif
  } state_t;

  localparam logic [5:0] X_LAST   = 6'(COLS - 1);
  localparam logic [4:0] Y_LAST   = 5'(ROWS - 1);
  // READ_LAT is assumed to be at least 1 (registered buffer read).
  localparam logic [3:0] LAT_LAST = 4'(READ_LAT - 1);
`ifdef FRAME_DUMP_HEADER_EN
  localparam logic [31:0] HDR_WORD = {8'hA5, 8'h5A, 8'(COLS), 8'(ROWS)};
`endif

  state_t                  state;
  state_t                  state_next;
  logic [HOLDOFF_BITS-1:0] hold_cnt;
  logic [31:0]             shreg;
  logic [1:0]              byte_idx;
  logic [3:0]              lat_cnt;
  logic                    ready;
  logic                    start_go;
  logic                    last_x;
  logic                    last_y;
  logic                    in_send;

  assign ready     = (&hold_cnt) & ~uart_busy_i & ~uart_wr_o;
  assign start_go  = (CONTINUOUS != 0) || start_i;
  assign last_x    = (read_x == X_LAST);
  assign last_y    = (read_y == Y_LAST);
  assign dbg_state = state;

`ifdef FRAME_DUMP_HEADER_EN
  assign in_send = (state == SEND) || (state == HDR);
`else
  assign in_send = (state == SEND);
`endif

  // State register.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) state <= IDLE;
    else           state <= state_next;
  end

  // Next-state decode plus the busy/done status flags.
  always_comb begin
    state_next = state;
    busy_o     = 1'b1;
    done_o     = 1'b0;
    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_go) begin
`ifdef FRAME_DUMP_HEADER_EN
          state_next = HDR;
`else
          state_next = ADDR;
`endif
        end
      end
`ifdef FRAME_DUMP_HEADER_EN
      HDR:   if (ready && byte_idx == 2'd3) state_next = ADDR;
`endif
      ADDR:  if (lat_cnt == LAT_LAST) state_next = LATCH;
      LATCH: state_next = SEND;
      SEND:  if (ready && byte_idx == 2'd3) state_next = NEXT;
      NEXT:  state_next = (last_x && last_y) ? DONE : ADDR;
      DONE: begin
        busy_o     = 1'b0;
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        busy_o     = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Holdoff counter: restarts on uart activity or our own strobe, saturates.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i)                    hold_cnt <= '0;
    else if (uart_busy_i | uart_wr_o) hold_cnt <= '0;
    else if (!(&hold_cnt))            hold_cnt <= hold_cnt + HOLDOFF_BITS'(1);
  end

  // Address walk, word capture and byte serialisation.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      read_x     <= '0;
      read_y     <= '0;
      uart_dat_o <= '0;
      uart_wr_o  <= 1'b0;
      shreg      <= '0;
      byte_idx   <= '0;
      lat_cnt    <= '0;
    end else begin
      uart_wr_o <= 1'b0;
      if (in_send && ready) begin
        uart_wr_o  <= 1'b1;
        uart_dat_o <= shreg[31:24];
        shreg      <= {shreg[23:0], 8'h00};
        byte_idx   <= byte_idx + 2'd1;
      end
      case (state)
        IDLE: begin
          if (start_go) begin
            read_x   <= '0;
            read_y   <= '0;
            byte_idx <= '0;
            lat_cnt  <= '0;
`ifdef FRAME_DUMP_HEADER_EN
            shreg    <= HDR_WORD;
`endif
          end
        end
        ADDR: begin
          if (lat_cnt == LAT_LAST) lat_cnt <= '0;
          else                     lat_cnt <= lat_cnt + 4'd1;
        end
        LATCH: begin
          shreg    <= read_q;
          byte_idx <= '0;
        end
        NEXT: begin
          if (last_x) begin
            read_x <= '0;
            read_y <= last_y ? 5'd0 : read_y + 5'd1;
          end else begin
            read_x <= read_x + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_uart_dumper.sv
// tb_frame_uart_dumper: directed bench for frame_uart_dumper with a 2x2 grid,
// 2-bit holdoff and CONTINUOUS=0. A buffer model returns indexed words, a uart
// model holds busy for 5 cycles after each strobe, and a scoreboard compares
// every strobed byte against the expected frame stream.
module tb_frame_uart_dumper;

  localparam int COLS = 2;
  localparam int ROWS = 2;
`ifdef FRAME_DUMP_HEADER_EN
  localparam int HDR_N = 4;
`else
  localparam int HDR_N = 0;
`endif
  localparam int FRAME_LEN = COLS * ROWS * 4 + HDR_N;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  read_x;
  logic [4:0]  read_y;
  logic [31:0] read_q = '0;
  logic [7:0]  uart_dat_o;
  logic        uart_wr_o;
  logic        uart_busy;
  logic        busy_o;
  logic        done_o;
  logic [2:0]  dbg_state;
  logic        busy_force = 1'b0;

  int checks = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  frame_uart_dumper #(
    .COLS(COLS), .ROWS(ROWS), .HOLDOFF_BITS(2), .READ_LAT(1), .CONTINUOUS(0)
  ) dut (
    .sys_clk_i(clk), .sys_rst_i(rst), .start_i(start),
    .read_x(read_x), .read_y(read_y), .read_q(read_q),
    .uart_dat_o(uart_dat_o), .uart_wr_o(uart_wr_o), .uart_busy_i(uart_busy),
    .busy_o(busy_o), .done_o(done_o), .dbg_state(dbg_state)
  );

  // ---------------- models ----------------
  function automatic logic [31:0] word_of(input int x, input int y);
    return 32'h11223344 + 32'h01010101 * 32'(y * COLS + x);
  endfunction

  // Buffer with one cycle of read latency.
  always @(posedge clk) read_q <= word_of(int'(read_x), int'(read_y));

  // Uart: busy for 5 cycles after each strobe, plus a bench override.
  int busy_left = 0;
  always @(posedge clk) begin
    if (uart_wr_o) busy_left <= 5;
    else if (busy_left > 0) busy_left <= busy_left - 1;
  end
  assign uart_busy = (busy_left != 0) || busy_force;

  // ---------------- scoreboard / monitor ----------------
  logic [7:0] exp_q[$];
  logic [7:0] log_byte[$];
  int strobe_cnt = 0;
  int done_cnt = 0;
  int last_strobe_cyc = -100;
  int last_busy_cyc = -100;
  logic done_busy = 1'b0;
  logic done_prev_busy = 1'b0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    logic [7:0] e;
    if (uart_wr_o === 1'b1) begin
      checks++;
      if (uart_busy !== 1'b0) begin
        failures++;
        $display("FAIL strobe_while_busy cyc=%0d busy=%b required=0", cyc, uart_busy);
      end
      checks++;
      if (cyc - last_strobe_cyc < 4) begin
        failures++;
        $display("FAIL strobe_spacing gap=%0d required>=4", cyc - last_strobe_cyc);
      end
      checks++;
      if (cyc - (last_busy_cyc + 1) < 4) begin
        failures++;
        $display("FAIL busy_fall_holdoff gap=%0d required>=4", cyc - (last_busy_cyc + 1));
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe got=%h required=none", uart_dat_o);
      end else begin
        e = exp_q.pop_front();
        if (uart_dat_o !== e) begin
          failures++;
          $display("FAIL strobe_byte idx=%0d got=%h required=%h", strobe_cnt, uart_dat_o, e);
        end
      end
      log_byte.push_back(uart_dat_o);
      strobe_cnt++;
      last_strobe_cyc = cyc;
    end
    if (uart_busy === 1'b1) last_busy_cyc = cyc;
    if (done_o === 1'b1) begin
      done_cnt++;
      done_busy = busy_o;
      done_prev_busy = prev_busy;
    end
    prev_busy = busy_o;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_frame();
    logic [31:0] w;
`ifdef FRAME_DUMP_HEADER_EN
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'(COLS));
    exp_q.push_back(8'(ROWS));
`endif
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        w = word_of(x, y);
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
      end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_strobes(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (strobe_cnt >= target) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++;
    if ({read_x, read_y, uart_dat_o, uart_wr_o, busy_o, done_o} !== 22'd0) begin
      failures++;
      $display("FAIL reset_outputs got x=%0d y=%0d dat=%h wr=%b busy=%b done=%b required all 0",
               read_x, read_y, uart_dat_o, uart_wr_o, busy_o, done_o);
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_idle_no_start();
    int s0;
    s0 = strobe_cnt;
    tick(100);
    checks++;
    if (strobe_cnt !== s0) begin
      failures++;
      $display("FAIL idle_no_strobe got=%0d required=%0d", strobe_cnt, s0);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL idle_busy got=%b required=0", busy_o);
    end
  endtask

  task automatic test_first_word_and_frame();
    logic [7:0] first[$];
    int base;
    int d0;
    bit ok;
    base = strobe_cnt;
    d0 = done_cnt;
`ifdef FRAME_DUMP_HEADER_EN
    first = '{8'hA5, 8'h5A, 8'h02, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
`else
    first = '{8'h11, 8'h22, 8'h33, 8'h44};
`endif
    push_frame();
    pulse_start();
    wait_strobes(base + first.size(), 2000, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL first_word_timeout got=%0d required=%0d", strobe_cnt - base, first.size());
    end else begin
      for (int i = 0; i < first.size(); i++) begin
        checks++;
        if (log_byte[base + i] !== first[i]) begin
          failures++;
          $display("FAIL first_word_byte%0d got=%h required=%h", i, log_byte[base + i], first[i]);
        end
      end
    end
    wait_done(d0 + 1, 3000, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL frame_done_timeout got=%0d required=%0d", done_cnt, d0 + 1);
    end
    checks++;
    if (done_busy !== 1'b0 || done_prev_busy !== 1'b1) begin
      failures++;
      $display("FAIL done_busy_fall got busy=%b prev=%b required busy=0 prev=1",
               done_busy, done_prev_busy);
    end
    tick(100);
    checks++;
    if (strobe_cnt - base !== FRAME_LEN) begin
      failures++;
      $display("FAIL frame_len got=%0d required=%0d", strobe_cnt - base, FRAME_LEN);
    end
    checks++;
    if (done_cnt !== d0 + 1) begin
      failures++;
      $display("FAIL single_frame_done got=%0d required=%0d", done_cnt, d0 + 1);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL frame_leftover got=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_busy_hold();
    int base;
    int d0;
    int s;
    bit ok;
    base = strobe_cnt;
    d0 = done_cnt;
    push_frame();
    pulse_start();
    wait_strobes(base + HDR_N + 5, 2000, ok);
    busy_force = 1'b1;
    s = strobe_cnt;
    tick(50);
    checks++;
    if (!ok || strobe_cnt !== s) begin
      failures++;
      $display("FAIL busy_hold_strobes got=%0d required=%0d ok=%b", strobe_cnt, s, ok);
    end
    busy_force = 1'b0;
    wait_done(d0 + 1, 3000, ok);
    tick(20);
    checks++;
    if (!ok || strobe_cnt - base !== FRAME_LEN || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL busy_hold_frame got=%0d left=%0d required=%0d left=0",
               strobe_cnt - base, exp_q.size(), FRAME_LEN);
    end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    int d0;
    logic [7:0] first_b;
    bit ok;
    base = strobe_cnt;
    d0 = done_cnt;
    push_frame();
    pulse_start();
    wait_strobes(base + 6, 2000, ok);
    rst = 1'b1;
    tick(1);
    checks++;
    if (!ok || {read_x, read_y, uart_dat_o, uart_wr_o, busy_o, done_o} !== 22'd0) begin
      failures++;
      $display("FAIL midframe_reset got x=%0d y=%0d dat=%h wr=%b busy=%b done=%b ok=%b required all 0",
               read_x, read_y, uart_dat_o, uart_wr_o, busy_o, done_o, ok);
    end
    rst = 1'b0;
    exp_q.delete();
    tick(50);
    checks++;
    if (strobe_cnt !== base + 6 || done_cnt !== d0) begin
      failures++;
      $display("FAIL abandoned_frame got strobes=%0d done=%0d required %0d and %0d",
               strobe_cnt - base, done_cnt, 6, d0);
    end
`ifdef FRAME_DUMP_HEADER_EN
    first_b = 8'hA5;
`else
    first_b = 8'h11;
`endif
    push_frame();
    pulse_start();
    wait_done(d0 + 1, 3000, ok);
    checks++;
    if (!ok || log_byte[base + 6] !== first_b || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL restart_after_reset got=%h left=%0d required=%h left=0",
               log_byte[base + 6], exp_q.size(), first_b);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int d0;
    bit ok;
    base = strobe_cnt;
    d0 = done_cnt;
    push_frame();
    push_frame();
    start = 1'b1;
    wait_done(d0 + 1, 3000, ok);
    tick(2);
    start = 1'b0;
    wait_done(d0 + 2, 3000, ok);
    tick(100);
    checks++;
    if (!ok || done_cnt !== d0 + 2 || strobe_cnt - base !== 2 * FRAME_LEN) begin
      failures++;
      $display("FAIL back_to_back got done=%0d strobes=%0d required done=%0d strobes=%0d",
               done_cnt - d0, strobe_cnt - base, 2, 2 * FRAME_LEN);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL back_to_back_leftover got=%0d required=0", exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_idle_no_start();
    test_first_word_and_frame();
    test_busy_hold();
    test_reset_mid_frame();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
